// File: rtl/gpsdo_pkg.sv
// gpsdo_pkg: shared types, constants and arithmetic helpers for the GPSDO
// disciplining loop. Holds the controller and serializer state encodings,
// the status-frame header, the status bit positions and the clamp helpers.
package gpsdo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERR,
    ST_INTEG,
    ST_DUTY,
    ST_TX_LOAD,
    ST_TX_WAIT
  } state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_GAP,
    TX_HOLD
  } tx_state_t;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  // Status byte layout: {lock_n, holdover, overrun, lead, 4'b0}
  localparam int unsigned ST_BIT_LOCK = 7;
  localparam int unsigned ST_BIT_HOLD = 6;
  localparam int unsigned ST_BIT_OVR  = 5;
  localparam int unsigned ST_BIT_LEAD = 4;

  // Datapath widths: loop arithmetic is signed 48-bit, e/integrator stored 34-bit
  localparam int unsigned CALC_W = 48;
  localparam int unsigned ERR_W  = 34;

  function automatic logic signed [CALC_W-1:0] clamp_s48(
    input logic signed [CALC_W-1:0] x,
    input logic signed [CALC_W-1:0] lo,
    input logic signed [CALC_W-1:0] hi
  );
    if (x < lo) return lo;
    else if (x > hi) return hi;
    else return x;
  endfunction

  function automatic logic [7:0] sat_s8(input logic signed [CALC_W-1:0] x);
    return 8'(clamp_s48(x, -48'sd128, 48'sd127));
  endfunction

endpackage

// File: rtl/gpsdo_frame_tx.sv
// gpsdo_frame_tx: serializes one 4-byte status frame (header, status, error,
// XOR checksum) over a Uart_En/Uart_Busy handshake.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_start latches
// i_status/i_err and begins a frame; i_busy transmitter busy; o_en one-cycle
// send strobe with o_data; o_done one-cycle pulse after the 4th byte.
module gpsdo_frame_tx
  import gpsdo_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_status,
  input  logic [7:0] i_err,
  input  logic       i_busy,
  output logic       o_en,
  output logic [7:0] o_data,
  output logic       o_done
);

  tx_state_t  r_state, w_state_nxt;
  logic [1:0] r_idx, w_idx_nxt;
  logic [7:0] r_status, r_err, r_chk, w_byte;
  logic [7:0] r_data;
  logic       r_en, r_done, w_en_nxt, w_done_nxt;

  // Byte selected by the current frame position
  always_comb begin
    case (r_idx)
      2'd0:    w_byte = FRAME_HDR;
      2'd1:    w_byte = r_status;
      2'd2:    w_byte = r_err;
      default: w_byte = r_chk;
    endcase
  end

  // Next state: send when idle, skip the strobe cycle, then wait for not-busy
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_en_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      TX_IDLE: if (i_start) begin
        w_state_nxt = TX_SEND;
        w_idx_nxt   = 2'd0;
      end
      TX_SEND: if (!i_busy) begin
        w_en_nxt    = 1'b1;
        w_state_nxt = TX_GAP;
      end
      TX_GAP:  w_state_nxt = TX_HOLD;
      TX_HOLD: if (!i_busy) begin
        if (r_idx == 2'd3) begin
          w_state_nxt = TX_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = TX_SEND;
          w_idx_nxt   = r_idx + 2'd1;
        end
      end
      default: w_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= TX_IDLE;
      r_idx    <= 2'd0;
      r_status <= 8'd0;
      r_err    <= 8'd0;
      r_chk    <= 8'd0;
      r_data   <= 8'd0;
      r_en     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_en    <= w_en_nxt;
      r_done  <= w_done_nxt;
      if (w_en_nxt) r_data <= w_byte;
      if (r_state == TX_IDLE && i_start) begin
        r_status <= i_status;
        r_err    <= i_err;
        r_chk    <= FRAME_HDR ^ i_status ^ i_err;
      end
    end
  end

  assign o_en   = r_en;
  assign o_data = r_data;
  assign o_done = r_done;

endmodule

// File: rtl/gpsdo_loop_ctrl.sv
// gpsdo_loop_ctrl: GPSDO disciplining loop. Turns each 1PPS phase measurement
// into a clamped PI update of the OCXO PWM duty, tracks lock and holdover,
// and reports every update as a 4-byte status frame.
// Ports: CLK_SYS/CLK_RST clock and async active-low reset; Phase_Valid/
// Phase_Lead/Phase_Cnt measurement; PWM_Duty, LED_Lock (0 = locked),
// Holdover status; Uart_Busy/Uart_En/Uart_Data transmitter handshake.
module gpsdo_loop_ctrl
  import gpsdo_pkg::*;
#(
  parameter int unsigned DUTY_CENTER = 33300,
  parameter int unsigned DUTY_MIN    = 0,
  parameter int unsigned DUTY_MAX    = 65535,
  parameter int unsigned KP_SHL      = 4,
  parameter int unsigned KI_SHR      = 2,
  parameter int unsigned ERR_MAX     = 5000000,
  parameter int unsigned INT_MAX     = 1000000,
  parameter int unsigned DEADBAND    = 2,
  parameter int unsigned LOCK_COUNT  = 8,
  parameter int unsigned UNLOCK_THR  = 20,
  parameter int unsigned TIMEOUT_CYC = 15000000
) (
  input  logic        CLK_SYS,
  input  logic        CLK_RST,
  input  logic        Phase_Valid,
  input  logic        Phase_Lead,
  input  logic [31:0] Phase_Cnt,
  output logic [31:0] PWM_Duty,
  output logic        LED_Lock,
  output logic        Holdover,
  input  logic        Uart_Busy,
  output logic        Uart_En,
  output logic [7:0]  Uart_Data
);

  localparam int unsigned LOCK_W = 8;
  localparam logic signed [CALC_W-1:0] C_CENTER   = CALC_W'(DUTY_CENTER);
  localparam logic signed [CALC_W-1:0] C_DUTY_MIN = CALC_W'(DUTY_MIN);
  localparam logic signed [CALC_W-1:0] C_DUTY_MAX = CALC_W'(DUTY_MAX);
  localparam logic signed [CALC_W-1:0] C_ERR_MAX  = CALC_W'(ERR_MAX);
  localparam logic signed [CALC_W-1:0] C_INT_MAX  = CALC_W'(INT_MAX);
  localparam logic signed [CALC_W-1:0] C_DEADBAND = CALC_W'(DEADBAND);
  localparam logic signed [CALC_W-1:0] C_UNLOCK   = CALC_W'(UNLOCK_THR);
  localparam logic [LOCK_W-1:0]        C_LOCK     = LOCK_W'(LOCK_COUNT);
  localparam logic [31:0]              C_TO       = 32'(TIMEOUT_CYC);

  state_t                   r_state, w_state_nxt;
  logic                     r_lead;
  logic [31:0]              r_cnt, r_to_cnt, r_duty;
  logic signed [ERR_W-1:0]  r_e, r_integ;
  logic [LOCK_W-1:0]        r_lock_cnt, w_lock_inc;
  logic                     r_led, r_hold, r_ovr, r_ovr_tx, r_hold_pend;
  logic signed [CALC_W-1:0] w_meas, w_e_sat, w_e_nxt, w_e48, w_integ48;
  logic signed [CALC_W-1:0] w_abs_e, w_int_nxt, w_duty_nxt;
  logic [7:0]               w_status, w_err_byte;
  logic                     w_to_hit, w_drop, w_tx_start, w_tx_done;

  // Loop arithmetic for the ERR, INTEG and DUTY stages
  always_comb begin
    w_meas = $signed({16'd0, r_cnt});
    if (r_lead) w_meas = -w_meas;
    w_e_sat    = clamp_s48(w_meas, -C_ERR_MAX, C_ERR_MAX);
    w_e_nxt    = (w_e_sat <= C_DEADBAND && w_e_sat >= -C_DEADBAND) ? '0 : w_e_sat;
    w_e48      = {{(CALC_W-ERR_W){r_e[ERR_W-1]}}, r_e};
    w_integ48  = {{(CALC_W-ERR_W){r_integ[ERR_W-1]}}, r_integ};
    w_abs_e    = w_e48[CALC_W-1] ? -w_e48 : w_e48;
    w_int_nxt  = clamp_s48(w_integ48 + w_e48, -C_INT_MAX, C_INT_MAX);
    w_duty_nxt = clamp_s48(C_CENTER + (w_e48 <<< KP_SHL) + (w_integ48 >>> KI_SHR),
                           C_DUTY_MIN, C_DUTY_MAX);
    w_lock_inc = (r_lock_cnt == C_LOCK) ? r_lock_cnt : r_lock_cnt + LOCK_W'(1);
    w_status   = '0;
    w_status[ST_BIT_LOCK] = r_led;
    w_status[ST_BIT_HOLD] = r_hold;
    w_status[ST_BIT_OVR]  = r_ovr;
    w_status[ST_BIT_LEAD] = r_lead;
    w_err_byte = sat_s8(w_e48);
  end

  // Expiry fires once; a coincident measurement suppresses it
  assign w_to_hit = !Phase_Valid && (r_to_cnt == C_TO - 32'd1);
  assign w_drop   = Phase_Valid && (r_state != ST_IDLE);

  // Next-state: measurement pipeline, then frame transmission
  always_comb begin
    w_state_nxt = r_state;
    w_tx_start  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Phase_Valid)      w_state_nxt = ST_ERR;
        else if (r_hold_pend) w_state_nxt = ST_TX_LOAD;
      end
      ST_ERR:     w_state_nxt = ST_INTEG;
      ST_INTEG:   w_state_nxt = ST_DUTY;
      ST_DUTY:    w_state_nxt = ST_TX_LOAD;
      ST_TX_LOAD: begin
        w_tx_start  = 1'b1;
        w_state_nxt = ST_TX_WAIT;
      end
      ST_TX_WAIT: if (w_tx_done) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      r_state     <= ST_IDLE;
      r_lead      <= 1'b0;
      r_cnt       <= '0;
      r_e         <= '0;
      r_integ     <= '0;
      r_lock_cnt  <= '0;
      r_to_cnt    <= '0;
      r_duty      <= 32'(DUTY_CENTER);
      r_led       <= 1'b1;
      r_hold      <= 1'b0;
      r_ovr       <= 1'b0;
      r_ovr_tx    <= 1'b0;
      r_hold_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (Phase_Valid)          r_to_cnt <= '0;
      else if (r_to_cnt != C_TO) r_to_cnt <= r_to_cnt + 32'd1;
      case (r_state)
        ST_IDLE: begin
          if (Phase_Valid) begin
            r_lead <= Phase_Lead;
            r_cnt  <= Phase_Cnt;
          end else if (r_hold_pend) begin
            // Holdover frame carries a zero error byte
            r_e         <= '0;
            r_hold_pend <= 1'b0;
          end
        end
        ST_ERR:   r_e <= ERR_W'(w_e_nxt);
        ST_INTEG: begin
          r_integ <= ERR_W'(w_int_nxt);
          if (r_e == '0) begin
            r_lock_cnt <= w_lock_inc;
            if (w_lock_inc == C_LOCK) r_led <= 1'b0;
          end else begin
            r_lock_cnt <= '0;
            if (w_abs_e > C_UNLOCK) r_led <= 1'b1;
          end
        end
        ST_DUTY:    r_duty <= 32'(w_duty_nxt);
        ST_TX_LOAD: r_ovr_tx <= 1'b0;
        // Overruns after the status byte was latched belong to the next frame
        ST_TX_WAIT: if (w_tx_done) r_ovr <= r_ovr_tx;
        default: ;
      endcase
      if (w_drop) begin
        r_ovr <= 1'b1;
        if (r_state == ST_TX_LOAD || r_state == ST_TX_WAIT) r_ovr_tx <= 1'b1;
      end
      if (Phase_Valid) begin
        r_hold      <= 1'b0;
        r_hold_pend <= 1'b0;
      end
      if (w_to_hit) begin
        r_hold      <= 1'b1;
        r_led       <= 1'b1;
        r_lock_cnt  <= '0;
        r_hold_pend <= 1'b1;
      end
    end
  end

  gpsdo_frame_tx u_frame_tx (
    .i_clk    (CLK_SYS),
    .i_rst_n  (CLK_RST),
    .i_start  (w_tx_start),
    .i_status (w_status),
    .i_err    (w_err_byte),
    .i_busy   (Uart_Busy),
    .o_en     (Uart_En),
    .o_data   (Uart_Data),
    .o_done   (w_tx_done)
  );

  assign PWM_Duty = r_duty;
  assign LED_Lock = r_led;
  assign Holdover = r_hold;

endmodule

// File: tb/tb_gpsdo_loop_ctrl.sv
// tb_gpsdo_loop_ctrl: directed-vector bench for gpsdo_loop_ctrl with a small
// UART busy responder that captures every transmitted byte.
module tb_gpsdo_loop_ctrl;

  logic        CLK_SYS;
  logic        CLK_RST;
  logic        Phase_Valid;
  logic        Phase_Lead;
  logic [31:0] Phase_Cnt;
  logic [31:0] PWM_Duty;
  logic        LED_Lock;
  logic        Holdover;
  logic        Uart_Busy;
  logic        Uart_En;
  logic [7:0]  Uart_Data;

  logic [7:0] rx_q[$];
  int         busy_cnt;
  int         n_vec;
  int         n_err;

  gpsdo_loop_ctrl #(.TIMEOUT_CYC(400)) dut (
    .CLK_SYS     (CLK_SYS),
    .CLK_RST     (CLK_RST),
    .Phase_Valid (Phase_Valid),
    .Phase_Lead  (Phase_Lead),
    .Phase_Cnt   (Phase_Cnt),
    .PWM_Duty    (PWM_Duty),
    .LED_Lock    (LED_Lock),
    .Holdover    (Holdover),
    .Uart_Busy   (Uart_Busy),
    .Uart_En     (Uart_En),
    .Uart_Data   (Uart_Data)
  );

  initial CLK_SYS = 1'b0;
  always #5 CLK_SYS = ~CLK_SYS;

  // Transmitter model: busy for 6 cycles after each strobe
  always @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      Uart_Busy <= 1'b0;
      busy_cnt  <= 0;
    end else if (Uart_En) begin
      Uart_Busy <= 1'b1;
      busy_cnt  <= 6;
      rx_q.push_back(Uart_Data);
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) Uart_Busy <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK_SYS);
    CLK_RST     = 1'b0;
    Phase_Valid = 1'b0;
    Phase_Lead  = 1'b0;
    Phase_Cnt   = '0;
    repeat (3) @(negedge CLK_SYS);
    rx_q.delete();
    CLK_RST = 1'b1;
    @(negedge CLK_SYS);
  endtask

  task automatic pulse(input logic lead, input logic [31:0] cnt);
    @(negedge CLK_SYS);
    Phase_Valid = 1'b1;
    Phase_Lead  = lead;
    Phase_Cnt   = cnt;
    @(negedge CLK_SYS);
    Phase_Valid = 1'b0;
    Phase_Lead  = 1'b0;
    Phase_Cnt   = '0;
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] st,
                              input logic [7:0] er, input logic [7:0] ck);
    logic [7:0]  exp_b[4];
    logic [31:0] got;
    int          n;
    exp_b[0] = 8'hA5;
    exp_b[1] = st;
    exp_b[2] = er;
    exp_b[3] = ck;
    n = 0;
    while (rx_q.size() < 4 && n < 400) begin
      @(negedge CLK_SYS);
      n++;
    end
    repeat (12) @(negedge CLK_SYS);
    chk({tag, "_len"}, 32'(rx_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (rx_q.size() != 0) got = {24'd0, rx_q.pop_front()};
      else got = 32'hFFFF_FFFF;
      chk($sformatf("%s_b%0d", tag, i), got, {24'd0, exp_b[i]});
    end
    rx_q.delete();
  endtask

  initial begin
    int n;
    n_vec       = 0;
    n_err       = 0;
    CLK_RST     = 1'b0;
    Phase_Valid = 1'b0;
    Phase_Lead  = 1'b0;
    Phase_Cnt   = '0;

    // Reset state
    do_reset();
    chk("rst_duty", PWM_Duty, 32'd33300);
    chk("rst_led",  {31'd0, LED_Lock}, 32'd1);
    chk("rst_hold", {31'd0, Holdover}, 32'd0);
    chk("rst_en",   {31'd0, Uart_En}, 32'd0);
    chk("rst_data", {24'd0, Uart_Data}, 32'd0);

    // GPS leads by 10: duty appears exactly three edges after the strobe
    pulse(1'b0, 32'd10);
    repeat (2) @(negedge CLK_SYS);
    chk("lat_k2", PWM_Duty, 32'd33300);
    @(negedge CLK_SYS);
    chk("lat_k3", PWM_Duty, 32'd33462);
    expect_frame("f_pos10", 8'h80, 8'h0A, 8'h2F);

    // Local leads by 10 from reset
    do_reset();
    pulse(1'b1, 32'd10);
    repeat (3) @(negedge CLK_SYS);
    chk("neg10_duty", PWM_Duty, 32'd33137);
    expect_frame("f_neg10", 8'h90, 8'hF6, 8'hC3);

    // Eight in-deadband updates declare lock
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      pulse(1'b0, 32'd2);
      if (i < 8) expect_frame($sformatf("f_db%0d", i), 8'h80, 8'h00, 8'h25);
    end
    expect_frame("f_db8", 8'h00, 8'h00, 8'hA5);
    chk("lock_led",  {31'd0, LED_Lock}, 32'd0);
    chk("lock_duty", PWM_Duty, 32'd33300);

    // Error above the unlock threshold drops lock
    pulse(1'b0, 32'd25);
    expect_frame("f_unlock", 8'h80, 8'h19, 8'h3C);
    chk("unlock_led",  {31'd0, LED_Lock}, 32'd1);
    chk("unlock_duty", PWM_Duty, 32'd33706);

    // Timeout enters holdover with duty frozen
    n = 0;
    while (!Holdover && n < 1000) begin
      @(negedge CLK_SYS);
      n++;
    end
    chk("hold_entry", {31'd0, Holdover}, 32'd1);
    chk("hold_led",   {31'd0, LED_Lock}, 32'd1);
    chk("hold_duty",  PWM_Duty, 32'd33706);

    // A measurement during the holdover frame is dropped and flagged
    n = 0;
    while (rx_q.size() < 1 && n < 200) begin
      @(negedge CLK_SYS);
      n++;
    end
    pulse(1'b0, 32'd5);
    expect_frame("f_hold", 8'hC0, 8'h00, 8'h65);
    chk("hold_exit",  {31'd0, Holdover}, 32'd0);
    chk("drop_duty",  PWM_Duty, 32'd33706);

    // Next update reports the overrun and keeps the integrator (25 >>> 2 = 6)
    pulse(1'b0, 32'd0);
    expect_frame("f_ovr", 8'hA0, 8'h00, 8'h05);
    chk("resume_duty", PWM_Duty, 32'd33306);
    pulse(1'b0, 32'd0);
    expect_frame("f_ovr_clr", 8'h80, 8'h00, 8'h25);

    // Error saturation drives duty to the upper clamp
    do_reset();
    pulse(1'b0, 32'd6000000);
    repeat (3) @(negedge CLK_SYS);
    chk("sat_duty", PWM_Duty, 32'd65535);
    expect_frame("f_sat", 8'h80, 8'h7F, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
